// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the ARM pipeline control/hazard unit and its datapath.
// The slave side is the control unit; the master side is the datapath (or a bench).
interface pipeline_ctrl_if;
  logic [31:0] InstrD;
  logic [3:0]  ALUFlags;
  logic        Match_1E_M;
  logic        Match_1E_W;
  logic        Match_2E_M;
  logic        Match_2E_W;
  logic        Match_12D_E;
  logic [1:0]  RegSrcD;
  logic [1:0]  ImmSrcD;
  logic        ALUSrcE;
  logic [3:0]  ALUControlE;
  logic        MemWriteM;
  logic        MemtoRegW;
  logic        RegWriteW;
  logic        PCSrcW;
  logic        BranchTakenE;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        FlushE;

  modport master (
    output InstrD, ALUFlags, Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
    input  RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, MemWriteM, MemtoRegW, RegWriteW, PCSrcW,
    input  BranchTakenE, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
  );

  modport slave (
    input  InstrD, ALUFlags, Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
    output RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, MemWriteM, MemtoRegW, RegWriteW, PCSrcW,
    output BranchTakenE, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Control and hazard unit for a 5-stage ARM pipeline: decode, D/E/M/W control
// registers, condition evaluation against NZCV, forwarding, stall and flush.
module pipeline_ctrl (
  input  logic           clk,
  input  logic           reset,
  pipeline_ctrl_if.slave bus
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       pcsrc;
    logic       branch;
    logic       alusrc;
    logic [3:0] aluctl;
    logic [1:0] flagw;
    logic [3:0] cond;
  } de_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memwrite;
    logic pcsrc;
    logic memtoreg;
  } em_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic pcsrc;
  } mw_ctrl_t;

  de_ctrl_t   dec;
  de_ctrl_t   de_d, de_q;
  em_ctrl_t   em_d, em_q;
  mw_ctrl_t   mw_d, mw_q;
  logic [3:0] flags_d, flags_q;
  logic [1:0] regsrc_dec, immsrc_dec;
  logic       condex_e;
  logic       ldr_stall;
  logic       pcwr_pend;
  logic       branch_taken_e;
  logic       flush_e;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_instr;

  assign op           = bus.InstrD[27:26];
  assign funct        = bus.InstrD[25:20];
  assign rd           = bus.InstrD[15:12];
  assign unused_instr = ^bus.InstrD[11:0];

  function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: cond_met = z;
      4'b0001: cond_met = ~z;
      4'b0010: cond_met = c;
      4'b0011: cond_met = ~c;
      4'b0100: cond_met = n;
      4'b0101: cond_met = ~n;
      4'b0110: cond_met = v;
      4'b0111: cond_met = ~v;
      4'b1000: cond_met = c & ~z;
      4'b1001: cond_met = ~c | z;
      4'b1010: cond_met = (n == v);
      4'b1011: cond_met = (n != v);
      4'b1100: cond_met = ~z & (n == v);
      4'b1101: cond_met = z | (n != v);
      4'b1110: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  endfunction

  // Decode stage
  always_comb begin
    dec        = '0;
    regsrc_dec = 2'b00;
    immsrc_dec = 2'b00;
    dec.cond   = bus.InstrD[31:28];
    case (op)
      2'b00: begin
        dec.alusrc = funct[5];
        case (funct[4:1])
          4'b0100: begin dec.regwrite = 1'b1; dec.aluctl = ALU_ADD; dec.flagw = {2{funct[0]}}; end
          4'b0010: begin dec.regwrite = 1'b1; dec.aluctl = ALU_SUB; dec.flagw = {2{funct[0]}}; end
          4'b0000: begin dec.regwrite = 1'b1; dec.aluctl = ALU_AND; dec.flagw = {funct[0], 1'b0}; end
          4'b1100: begin dec.regwrite = 1'b1; dec.aluctl = ALU_ORR; dec.flagw = {funct[0], 1'b0}; end
          4'b1010: begin dec.aluctl = ALU_SUB; dec.flagw = {2{funct[0]}}; end
          default: ;
        endcase
      end
      2'b01: begin
        dec.alusrc = 1'b1;
        immsrc_dec = 2'b01;
        if (funct[0]) begin
          dec.regwrite = 1'b1;
          dec.memtoreg = 1'b1;
        end else begin
          dec.memwrite = 1'b1;
          regsrc_dec   = 2'b10;
        end
      end
      2'b10: begin
        dec.branch = 1'b1;
        dec.alusrc = 1'b1;
        immsrc_dec = 2'b10;
        regsrc_dec = 2'b01;
      end
      default: ;
    endcase
    dec.pcsrc = dec.regwrite & (rd == 4'hF);
  end

  // Execute stage: condition check gates every architectural side effect
  assign condex_e       = cond_met(de_q.cond, flags_q);
  assign branch_taken_e = de_q.branch & condex_e;

  always_comb begin
    flags_d = flags_q;
    if (de_q.flagw[1] & condex_e) flags_d[3:2] = bus.ALUFlags[3:2];
    if (de_q.flagw[0] & condex_e) flags_d[1:0] = bus.ALUFlags[1:0];
  end

  assign ldr_stall = bus.Match_12D_E & de_q.memtoreg;
  assign pcwr_pend = dec.pcsrc | de_q.pcsrc | em_q.pcsrc;
  assign flush_e   = ldr_stall | branch_taken_e;

  assign de_d = flush_e ? '0 : dec;
  assign em_d = '{regwrite: de_q.regwrite & condex_e,
                  memwrite: de_q.memwrite & condex_e,
                  pcsrc:    de_q.pcsrc & condex_e,
                  memtoreg: de_q.memtoreg};
  assign mw_d = '{regwrite: em_q.regwrite, memtoreg: em_q.memtoreg, pcsrc: em_q.pcsrc};

  // D->E, E->M, M->W boundaries and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      de_q    <= '0;
      em_q    <= '0;
      mw_q    <= '0;
      flags_q <= '0;
    end else begin
      de_q    <= de_d;
      em_q    <= em_d;
      mw_q    <= mw_d;
      flags_q <= flags_d;
    end
  end

  // Memory result beats writeback result when both stages match
  always_comb begin
    bus.ForwardAE = 2'b00;
    if (bus.Match_1E_M & em_q.regwrite)      bus.ForwardAE = 2'b10;
    else if (bus.Match_1E_W & mw_q.regwrite) bus.ForwardAE = 2'b01;
    bus.ForwardBE = 2'b00;
    if (bus.Match_2E_M & em_q.regwrite)      bus.ForwardBE = 2'b10;
    else if (bus.Match_2E_W & mw_q.regwrite) bus.ForwardBE = 2'b01;
  end

  assign bus.RegSrcD      = regsrc_dec;
  assign bus.ImmSrcD      = immsrc_dec;
  assign bus.ALUSrcE      = de_q.alusrc;
  assign bus.ALUControlE  = de_q.aluctl;
  assign bus.MemWriteM    = em_q.memwrite;
  assign bus.MemtoRegW    = mw_q.memtoreg;
  assign bus.RegWriteW    = mw_q.regwrite;
  assign bus.PCSrcW       = mw_q.pcsrc;
  assign bus.BranchTakenE = branch_taken_e;
  assign bus.StallF       = ldr_stall | pcwr_pend;
  assign bus.StallD       = ldr_stall;
  assign bus.FlushD       = pcwr_pend | mw_q.pcsrc | branch_taken_e;
  assign bus.FlushE       = flush_e;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Control and hazard unit for the 5-stage pipelined ARM datapath. It decodes the instruction held in Decode and carries its control bits through internal D→E, E→M and M→W control registers. In Execute it evaluates the condition field against an internal NZCV flags register. It also generates all forwarding, stall and flush signals the datapath consumes.

## Interface
Parameters:
- none.

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears every internal register.
- InstrD  in  32  Decode-stage instruction; bits [31:12] used (Cond, Op, Funct, Rd).
- ALUFlags  in  4  NZCV from the Execute-stage ALU.
- Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W  in  1 each  register-number matches of Execute sources A/B against Memory/Writeback destinations.
- Match_12D_E  in  1  a Decode source matches the Execute destination.
- RegSrcD  out  2  Decode register-address select.
- ImmSrcD  out  2  Decode immediate format.
- ALUSrcE  out  1  Execute SrcB select (1 = immediate).
- ALUControlE  out  4  encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 ORR.
- MemWriteM  out  1  data-memory write strobe.
- MemtoRegW, RegWriteW, PCSrcW  out  1 each  Writeback result select, register-file write, PC-from-result.
- BranchTakenE  out  1  branch resolved taken in Execute.
- ForwardAE, ForwardBE  out  2 each  00 register file, 01 ResultW, 10 ALUOutM.
- StallF, StallD  out  1 each  1 = hold PC / Fetch→Decode register.
- FlushD, FlushE  out  1 each  1 = clear Fetch→Decode / Decode→Execute register at next edge.

## Operation
Decode is combinational on InstrD.
- Op=00, data processing:
  - ALUSrc=Funct[5]; ImmSrc=00; RegSrc=00.
  - Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, RegWrite=0). All others: RegWrite=0, MemWrite=0.
  - RegWrite=1 for ADD/SUB/AND/ORR.
  - FlagW applies only when S (Funct[0]) is set: ADD/SUB/CMP write NZCV (11); AND/ORR write NZ (10).
- Op=01, memory: ALUSrc=1; ImmSrc=01; ALU ADD.
  - L=Funct[0]=1 (LDR): RegWrite=1, MemtoReg=1.
  - L=0 (STR): MemWrite=1, RegSrc=10.
- Op=10, branch: Branch=1, ALUSrc=1, ImmSrc=10, RegSrc=01, ALU ADD.
- Op=11: NOP (all write/branch bits 0).
- PCSrcD = RegWriteD & (Rd==4'hF).

Control pipeline:
- D→E register: RegWrite, MemtoReg, MemWrite, PCSrc, Branch, ALUSrc, ALUControl, FlagW, Cond. FlushE zeroes it.
- E→M register: RegWriteE&CondExE, MemWriteE&CondExE, PCSrcE&CondExE, MemtoRegE.
- M→W register: RegWrite, MemtoReg, PCSrc.

Condition evaluation:
- CondExE is evaluated from CondE and the Flags register using standard ARM codes 0000 EQ through 1110 AL. Code 1111 gives CondExE=0.
- BranchTakenE = BranchE & CondExE.
- Flags NZ are loaded from ALUFlags[3:2] when FlagWE[1]&CondExE; CV from ALUFlags[1:0] when FlagWE[0]&CondExE.

Hazards (combinational):
- ForwardAE = 10 if Match_1E_M&RegWriteM; else 01 if Match_1E_W&RegWriteW; else 00. ForwardBE uses the same rule with Match_2E_*.
- LDRStall = Match_12D_E & MemtoRegE.
- PCWrPend = PCSrcD | PCSrcE | PCSrcM.
- StallF = LDRStall | PCWrPend.
- StallD = LDRStall.
- FlushD = PCWrPend | PCSrcW | BranchTakenE.
- FlushE = LDRStall | BranchTakenE.

## Timing
- Reset: every control register and Flags go to 0. With InstrD=0 (reset value of the Fetch→Decode register), all outputs are 0.
- Control for an instruction in D appears on E outputs 1 cycle later, on M outputs 2 cycles later, and on W outputs 3 cycles later.
- Load-use costs exactly 1 bubble: StallF, StallD and FlushE are high for one cycle.
- Taken branch: FlushD and FlushE are high during the Execute cycle; 2 instructions are squashed.
- PC write: StallF is high for 3 cycles (D, E, M). FlushD is high for 4 cycles (D, E, M, W).
- Simultaneous events:
  - LDRStall with BranchTakenE: both flushes assert and the branch wins (StallD is ignored because FlushD clears).
  - Condition failed: MemWrite/RegWrite/PCSrc are suppressed and Flags do not update.
- Reset mid-pipeline: all in-flight control is dropped at the next edge.

## Test plan
- Reset with InstrD=0 → all outputs 0; Flags=0000.
- ADDS r1,r2,r3 (0xE0921003) in D; one cycle later ALUFlags=0100 → next cycle Flags=0100. Then BEQ 0x0A000002 in E → BranchTakenE=1, FlushD=1, FlushE=1.
- BEQ in E with Z=0 → BranchTakenE=0; no flush.
- LDR r1 in E (0xE5921000) with Match_12D_E=1 → StallF=StallD=FlushE=1 for exactly 1 cycle. The dependent instruction then sees Match_1E_W=1 → ForwardAE=01.
- RegWriteM=RegWriteW=1 with all Match_* =1 → ForwardAE=ForwardBE=10. With RegWriteM=0 → both 01.
- ADD pc,r2,r3 (0xE082F003) in D → StallF=1 for 3 cycles and FlushD=1 for 4 cycles; PCSrcW=1 and RegWriteW=1 in the 4th cycle.
